// File: rtl/iobus_timer_pkg.sv
// Shared register-map offsets and CTRL bit positions for the I/O bus timer.
package iobus_timer_pkg;

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COMPARE  = 3'd2;
    localparam logic [2:0] OFF_COUNT    = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_AUTO  = 1;
    localparam int CTRL_IRQEN = 2;
    localparam int CTRL_W     = 3;

endpackage

// File: rtl/iobus_timer_if.sv
// CPU I/O bus as seen by a peripheral, plus the interrupt line back to the CPU.
// Handshake: no valid/ready; IOBUS_WR qualifies a one-cycle write, reads are combinational.
interface iobus_timer_if;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic        INTR;

    modport master (
        output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR,
        input  IOBUS_IN, INTR
    );

    modport slave (
        input  IOBUS_ADDR, IOBUS_OUT, IOBUS_WR,
        output IOBUS_IN, INTR
    );
endinterface

// File: rtl/iobus_timer_prescaler.sv
// Divides the clock by (div+1) while enabled; tick is a one-cycle pulse.
module timer_prescaler (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] div,
    output logic        tick
);

    logic [31:0] r_pre;

    assign tick = en && (r_pre == div);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pre <= '0;
        end else if (clr || !en || tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 32'd1;
        end
    end

endmodule

// File: rtl/iobus_timer.sv
// Memory-mapped timer/counter with compare match and level interrupt on the CPU I/O bus.
module iobus_timer
    import iobus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1100_0100,
    parameter logic [31:0] PRESCALE_RST = 32'd0
) (
    input  logic          CLK,
    input  logic          RST_N,
    iobus_timer_if.slave  bus
);

    logic [CTRL_W-1:0] r_ctrl;
    logic [31:0]       r_prescale;
    logic [31:0]       r_compare;
    logic [31:0]       r_count;
    logic              r_match;
    logic              r_intr;

    logic              w_hit;
    logic [2:0]        w_off;
    logic              w_wr;
    logic              w_wr_ctrl;
    logic              w_wr_prescale;
    logic              w_wr_compare;
    logic              w_wr_count;
    logic              w_wr_status;
    logic              w_tick;
    logic              w_cmp_eq;
    logic              w_match_evt;
    logic              w_match_next;
    logic [CTRL_W-1:0] w_ctrl_next;
    logic [31:0]       w_count_next;
    logic [31:0]       w_rdata;
    logic              w_unused_addr_lsb;

    assign w_hit         = (bus.IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
    assign w_off         = bus.IOBUS_ADDR[4:2];
    assign w_wr          = bus.IOBUS_WR && w_hit;
    assign w_wr_ctrl     = w_wr && (w_off == OFF_CTRL);
    assign w_wr_prescale = w_wr && (w_off == OFF_PRESCALE);
    assign w_wr_compare  = w_wr && (w_off == OFF_COMPARE);
    assign w_wr_count    = w_wr && (w_off == OFF_COUNT);
    assign w_wr_status   = w_wr && (w_off == OFF_STATUS);
    assign w_unused_addr_lsb = &{1'b0, bus.IOBUS_ADDR[1:0]};

    timer_prescaler u_prescaler (
        .CLK   (CLK),
        .RST_N (RST_N),
        .en    (r_ctrl[CTRL_EN]),
        .clr   (w_wr_ctrl || w_wr_prescale),
        .div   (r_prescale),
        .tick  (w_tick)
    );

    // A CPU write to COUNT wins over a tick, so no match is evaluated that cycle.
    // The compare uses the registered COMPARE, even if it is being rewritten now.
    assign w_cmp_eq     = (r_count == r_compare);
    assign w_match_evt  = w_tick && !w_wr_count && w_cmp_eq;
    assign w_match_next = w_match_evt || (r_match && !(w_wr_status && bus.IOBUS_OUT[0]));
    assign w_ctrl_next  = w_wr_ctrl ? bus.IOBUS_OUT[CTRL_W-1:0] : r_ctrl;

    always_comb begin
        w_count_next = r_count;
        if (w_wr_count) begin
            w_count_next = bus.IOBUS_OUT;
        end else if (w_tick) begin
            if (w_cmp_eq && r_ctrl[CTRL_AUTO]) begin
                w_count_next = '0;
            end else begin
                w_count_next = r_count + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ctrl     <= '0;
            r_prescale <= PRESCALE_RST;
            r_compare  <= 32'hFFFF_FFFF;
            r_count    <= '0;
            r_match    <= 1'b0;
            r_intr     <= 1'b0;
        end else begin
            r_ctrl  <= w_ctrl_next;
            r_count <= w_count_next;
            r_match <= w_match_next;
            r_intr  <= w_match_next && w_ctrl_next[CTRL_IRQEN];
            if (w_wr_prescale) begin
                r_prescale <= bus.IOBUS_OUT;
            end
            if (w_wr_compare) begin
                r_compare <= bus.IOBUS_OUT;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_off)
                OFF_CTRL:     w_rdata = {{(32-CTRL_W){1'b0}}, r_ctrl};
                OFF_PRESCALE: w_rdata = r_prescale;
                OFF_COMPARE:  w_rdata = r_compare;
                OFF_COUNT:    w_rdata = r_count;
                OFF_STATUS:   w_rdata = {31'd0, r_match};
                default:      w_rdata = '0;
            endcase
        end
    end

    assign bus.IOBUS_IN = w_rdata;
    assign bus.INTR     = r_intr;

endmodule

// File: tb/tb_iobus_timer.sv
// Directed bench for iobus_timer: each task occupies one clock cycle; reads and INTR samples go through a scoreboard queue.
module tb_iobus_timer;

    localparam logic [31:0] BASE       = 32'h1100_0100;
    localparam logic [31:0] A_CTRL     = BASE + 32'h00;
    localparam logic [31:0] A_PRESCALE = BASE + 32'h04;
    localparam logic [31:0] A_COMPARE  = BASE + 32'h08;
    localparam logic [31:0] A_COUNT    = BASE + 32'h0C;
    localparam logic [31:0] A_STATUS   = BASE + 32'h10;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    iobus_timer_if bus ();

    iobus_timer #(
        .BASE_ADDR    (BASE),
        .PRESCALE_RST (32'd0)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    logic [31:0] exp_q[$];
    logic        kind_q[$];
    string       name_q[$];
    logic        chk_valid = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] mon_exp;
    logic [31:0] mon_act;
    logic        mon_kind;
    string       mon_name;

    // Monitor: whenever a sample is flagged, pop the oldest expectation and compare.
    always @(negedge CLK) begin
        if (chk_valid) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample actual=%h required=none", bus.IOBUS_IN);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_kind = kind_q.pop_front();
                mon_name = name_q.pop_front();
                mon_act  = mon_kind ? {31'd0, bus.INTR} : bus.IOBUS_IN;
                checks++;
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL %s actual=%h required=%h", mon_name, mon_act, mon_exp);
                end
            end
        end
    end

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        chk_valid      = 1'b0;
        bus.IOBUS_ADDR = addr;
        bus.IOBUS_OUT  = data;
        bus.IOBUS_WR   = 1'b1;
        @(posedge CLK);
        #1;
        bus.IOBUS_WR   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        bus.IOBUS_ADDR = addr;
        bus.IOBUS_WR   = 1'b0;
        exp_q.push_back(exp);
        kind_q.push_back(1'b0);
        name_q.push_back(nm);
        chk_valid = 1'b1;
        @(posedge CLK);
        #1;
        chk_valid = 1'b0;
    endtask

    task automatic chk_intr(input logic exp, input string nm);
        bus.IOBUS_WR = 1'b0;
        exp_q.push_back({31'd0, exp});
        kind_q.push_back(1'b1);
        name_q.push_back(nm);
        chk_valid = 1'b1;
        @(posedge CLK);
        #1;
        chk_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        chk_valid    = 1'b0;
        bus.IOBUS_WR = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.IOBUS_ADDR = 32'd0;
        bus.IOBUS_OUT  = 32'd0;
        bus.IOBUS_WR   = 1'b0;
        @(posedge CLK);
        #1;
        idle(2);
        RST_N = 1'b1;
        idle(1);

        // Get INTR up, then pull reset mid-cycle: everything must clear without an edge
        wr(A_COMPARE, 32'd2);
        wr(A_CTRL, 32'd7);
        idle(5);
        chk_intr(1'b1, "intr_before_reset");
        RST_N = 1'b0;
        chk_intr(1'b0, "intr_async_reset");
        rd(A_COUNT, 32'd0, "count_in_reset");
        idle(1);
        RST_N = 1'b1;
        rd(A_CTRL,     32'd0,          "rst_ctrl");
        rd(A_PRESCALE, 32'd0,          "rst_prescale");
        rd(A_COMPARE,  32'hFFFF_FFFF,  "rst_compare");
        rd(A_COUNT,    32'd0,          "rst_count");
        rd(A_STATUS,   32'd0,          "rst_status");
        chk_intr(1'b0, "rst_intr");
        rd(32'h1100_0118, 32'd0, "reserved_read");
        rd(32'h1100_0200, 32'd0, "miss_read_rst");

        // Prescale by 4: COUNT = floor(cycles_since_ctrl_write / 4)
        wr(A_PRESCALE, 32'd3);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'd1);
        idle(40);
        rd(A_COUNT, 32'd10, "presc_count_40");
        chk_intr(1'b0, "presc_no_intr");
        rd(A_COUNT, 32'd10, "presc_count_42");
        idle(1);
        rd(A_COUNT, 32'd11, "presc_count_44");
        wr(A_CTRL, 32'd0);
        rd(A_COUNT, 32'd11, "presc_frozen");
        rd(A_PRESCALE, 32'd3, "presc_readback");
        rd(A_CTRL, 32'd0, "ctrl_readback0");

        // Auto-reload with IRQ: COUNT after ctrl edge + t is t mod 6, match every 6th tick
        wr(A_PRESCALE, 32'd0);
        wr(A_COUNT, 32'd0);
        wr(A_COMPARE, 32'd5);
        wr(A_CTRL, 32'd7);
        rd(A_COUNT, 32'd0, "ar_count_t0");                 // t0
        rd(A_COUNT, 32'd1, "ar_count_t1");                 // t1
        rd(A_COUNT, 32'd2, "ar_count_t2");                 // t2
        rd(A_STATUS, 32'd0, "ar_status_t3");               // t3
        chk_intr(1'b0, "ar_intr_t4");                      // t4
        rd(A_COUNT, 32'd5, "ar_count_t5");                 // t5
        rd(A_STATUS, 32'd1, "ar_status_t6");               // t6
        chk_intr(1'b1, "ar_intr_t7");                      // t7
        rd(A_COUNT, 32'd2, "ar_count_t8");                 // t8
        wr(A_STATUS, 32'd1);                               // t9
        chk_intr(1'b0, "ar_intr_cleared");                 // t10
        rd(A_STATUS, 32'd0, "ar_status_cleared");          // t11
        chk_intr(1'b1, "ar_intr_rematch");                 // t12
        rd(A_STATUS, 32'd1, "ar_status_rematch");          // t13
        wr(A_STATUS, 32'd1);                               // t14
        rd(A_STATUS, 32'd0, "ar_status_clr2");             // t15
        rd(32'h1100_0208, 32'd0, "miss_read_compare");     // t16
        wr(A_STATUS, 32'd1);                               // t17: W1C on the matching edge
        rd(A_STATUS, 32'd1, "w1c_vs_match");               // t18
        chk_intr(1'b1, "w1c_vs_match_intr");               // t19
        wr(A_COUNT, 32'h100);                              // t20: COUNT write on a tick edge
        rd(A_COUNT, 32'h100, "count_write_vs_tick");       // t21
        rd(A_COUNT, 32'h101, "count_after_write");         // t22
        wr(A_CTRL, 32'd0);                                 // t23: tick still taken this edge
        rd(A_COUNT, 32'h103, "disable_count");             // t24
        rd(A_STATUS, 32'd1, "disable_match_held");         // t25
        chk_intr(1'b0, "disable_irqen_off");               // t26
        rd(A_COUNT, 32'h103, "disable_frozen");            // t27
        wr(A_CTRL, 32'd4);                                 // t28
        chk_intr(1'b1, "irqen_only_intr");                 // t29
        rd(A_COUNT, 32'h103, "irqen_only_frozen");         // t30
        rd(A_CTRL, 32'd4, "ctrl_readback4");               // t31

        // Free-run wrap, no reload, no IRQ: COUNT after ctrl edge + t is FFFF_FFFE + t
        wr(A_STATUS, 32'd1);
        rd(A_STATUS, 32'd0, "wrap_pre_clear");
        wr(A_COMPARE, 32'h10);
        wr(A_COUNT, 32'hFFFF_FFFE);
        wr(A_CTRL, 32'd1);
        rd(A_COUNT, 32'hFFFF_FFFE, "wrap_t0");             // t0
        rd(A_COUNT, 32'hFFFF_FFFF, "wrap_t1");             // t1
        rd(A_COUNT, 32'h0, "wrap_t2");                     // t2
        rd(A_COUNT, 32'h1, "wrap_t3");                     // t3
        rd(A_STATUS, 32'd0, "wrap_no_match");              // t4
        chk_intr(1'b0, "wrap_no_intr");                    // t5
        idle(12);
        rd(A_STATUS, 32'd0, "wrap_at_compare");            // t18
        rd(A_STATUS, 32'd1, "wrap_match_set");             // t19
        rd(A_COUNT, 32'h12, "wrap_no_reload");             // t20
        chk_intr(1'b0, "wrap_intr_masked");                // t21
        wr(A_CTRL, 32'd0);                                 // t22
        wr(32'h1100_020C, 32'h55);
        wr(32'h1100_0114, 32'hAA);
        rd(A_COUNT, 32'h15, "miss_write_ignored");
        rd(32'h1100_0114, 32'd0, "reserved_write_ignored");
        rd(A_STATUS, 32'd1, "final_status");

        idle(2);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
